// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory responder.
//   dmem_state_e : responder FSM states
//   dmem_req_t   : captured request (word index, write flag, byte mask, data, out-of-range)
//   dmem_merge_bytes : byte-lane merge used by the RAM write and read-during-write paths
package dmem_pkg;

    localparam int unsigned DMEM_MAX_LATENCY = 15;
    localparam int unsigned DMEM_CNT_W       = 4;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } dmem_state_e;

    typedef struct packed {
        logic [29:0] word_idx;
        logic        is_write;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        oor;
    } dmem_req_t;

    function automatic logic [31:0] dmem_merge_bytes(input logic [31:0] old_word,
                                                     input logic [31:0] new_word,
                                                     input logic [3:0]  be);
        logic [31:0] r;
        r = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// dmem_sram_array: DEPTH x 32 synchronous RAM with per-byte write enables.
//   clk_i            clock
//   we_i/waddr_i     write enable / word address
//   wbe_i/wdata_i    byte enables / write data
//   re_i/raddr_i     read enable / word address (registered read)
//   rdata_o          read data, holds until the next read; read-during-write
//                    to the same word returns the newly written bytes
module dmem_sram_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [3:0]    wbe_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;
    logic [31:0] rd_word;

    always_comb begin
        rd_word = mem_q[raddr_i];
        if (we_i && (waddr_i == raddr_i)) begin
            rd_word = dmem_merge_bytes(rd_word, wdata_i, wbe_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= dmem_merge_bytes(mem_q[waddr_i], wdata_i, wbe_i);
        if (re_i) rdata_q <= rd_word;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core data-memory port.
//   clk, rst           clock, asynchronous active-high reset
//   dmem_addr          byte address (bits [1:0] ignored)
//   dmem_rmask         read byte mask, nonzero = read request
//   dmem_wmask         write byte mask, nonzero = write request
//   dmem_wdata         write data
//   dmem_rdata         full read word, valid while dmem_resp=1
//   dmem_resp          one-cycle completion pulse, LATENCY cycles after request
//   proto_err          sticky protocol / range error
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        proto_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_e           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t             req_q, req_d, in_req;
    logic                  err_q, err_d;
    logic                  resp_q, resp_d;
    logic                  req, accept;
    logic [31:0]           sram_rdata;
    logic                  unused_bits;

    always_comb begin
        req             = (|dmem_rmask) || (|dmem_wmask);
        // resp_q marks the final BUSY cycle, so a new access can be taken there
        accept          = req && ((state_q == ST_IDLE) || resp_q);

        in_req.word_idx = dmem_addr[31:2];
        in_req.is_write = |dmem_wmask;
        in_req.wmask    = dmem_wmask;
        in_req.wdata    = dmem_wdata;
        in_req.oor      = dmem_addr[31:2] >= 30'(DEPTH);

        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;

        if (accept) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
            req_d   = in_req;
        end else if (resp_q) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (req && (((|dmem_rmask) && (|dmem_wmask)) || !accept || in_req.oor)) begin
            err_d = 1'b1;
        end

        // Response is registered: it is high in the cycle the counter sits at 0
        resp_d = (state_d == ST_BUSY) && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
            resp_q  <= resp_d;
        end
    end

    // Reads sample the RAM at acceptance: the only write that can commit before
    // the response is one on the acceptance edge, covered by read-during-write.
    dmem_sram_array #(
        .DEPTH(DEPTH)
    ) u_sram (
        .clk_i  (clk),
        .we_i   (resp_q && req_q.is_write && !req_q.oor),
        .waddr_i(req_q.word_idx[AW-1:0]),
        .wbe_i  (req_q.wmask),
        .wdata_i(req_q.wdata),
        .re_i   (accept && !in_req.is_write),
        .raddr_i(dmem_addr[AW+1:2]),
        .rdata_o(sram_rdata)
    );

    assign dmem_resp  = resp_q;
    assign dmem_rdata = (resp_q && !req_q.is_write && !req_q.oor) ? sram_rdata : '0;
    assign proto_err  = err_q;

    assign unused_bits = ^{dmem_addr[1:0], req_q.word_idx[29:AW]};

endmodule
